// File: rtl/vc_read_arbiter.sv
// Read-side arbiter for the VC0/VC1 transaction FIFOs: pops the head word of one
// VC per cycle (VC0 first) and pushes it, one cycle later, into the destination FIFO picked by its class field.
module vc_read_arbiter #(
  parameter int data_width = 6,
  parameter int dest_lsb   = 4,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [data_width-1:0] vc0_data,
  input  logic                  vc0_empty,
  input  logic [data_width-1:0] vc1_data,
  input  logic                  vc1_empty,
  input  logic [3:0]            d_almost_full,
  input  logic [3:0]            d_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic [3:0]            d_push,
  output logic [data_width-1:0] d_data,
  output logic                  idle,
  output logic                  active,
  output logic [cnt_width-1:0]  vc0_xfer_cnt,
  output logic [cnt_width-1:0]  vc1_xfer_cnt
);

  // Handshake: a source word transfers on the clk edge where ~vcX_empty & vcX_pop
  // (empty acts as inverted valid, pop as ready); destination k accepts whenever
  // it is neither full nor almost-full, and d_push is a one-cycle strobe with d_data.
  typedef enum logic [1:0] {
    st_init   = 2'd0,
    st_idle   = 2'd1,
    st_active = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0] blk;
  logic [1:0] dest0, dest1;
  logic       run;
  logic       any_data;

  assign blk      = d_almost_full | d_full;
  assign dest0    = vc0_data[dest_lsb+1:dest_lsb];
  assign dest1    = vc1_data[dest_lsb+1:dest_lsb];
  assign any_data = ~vc0_empty | ~vc1_empty;
  assign run      = reset & init & (state_q != st_init);

  // VC1 only waits on VC0 when VC0 actually pops, so a blocked VC0 never stalls VC1.
  assign vc0_pop = run & ~vc0_empty & ~blk[dest0];
  assign vc1_pop = run & ~vc1_empty & ~blk[dest1] & ~vc0_pop;

  assign idle   = (state_q == st_idle);
  assign active = (state_q == st_active);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= st_init;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!init) begin
      state_d = st_init;
    end else begin
      case (state_q)
        st_init:   state_d = any_data ? st_active : st_idle;
        st_idle:   if (any_data) state_d = st_active;
        st_active: if (!any_data && !vc0_pop && !vc1_pop) state_d = st_idle;
        default:   state_d = st_init;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_push       <= '0;
      d_data       <= '0;
      vc0_xfer_cnt <= '0;
      vc1_xfer_cnt <= '0;
    end else if (!init) begin
      d_push       <= '0;
      d_data       <= '0;
      vc0_xfer_cnt <= '0;
      vc1_xfer_cnt <= '0;
    end else if (vc0_pop) begin
      d_push       <= 4'b0001 << dest0;
      d_data       <= vc0_data;
      vc0_xfer_cnt <= vc0_xfer_cnt + cnt_width'(1);
    end else if (vc1_pop) begin
      d_push       <= 4'b0001 << dest1;
      d_data       <= vc1_data;
      vc1_xfer_cnt <= vc1_xfer_cnt + cnt_width'(1);
    end else begin
      d_push <= '0;
    end
  end

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Directed bench for vc_read_arbiter: hand-computed vectors for reset, priority,
// work-conserving routing, blocking, streaming with counter wrap, init drop and reset.
module tb_vc_read_arbiter;

  localparam int data_width = 6;
  localparam int cnt_width  = 8;

  logic                  clk;
  logic                  reset;
  logic                  init;
  logic [data_width-1:0] vc0_data;
  logic                  vc0_empty;
  logic [data_width-1:0] vc1_data;
  logic                  vc1_empty;
  logic [3:0]            d_almost_full;
  logic [3:0]            d_full;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic [3:0]            d_push;
  logic [data_width-1:0] d_data;
  logic                  idle;
  logic                  active;
  logic [cnt_width-1:0]  vc0_xfer_cnt;
  logic [cnt_width-1:0]  vc1_xfer_cnt;

  int n_cmp;
  int n_err;

  vc_read_arbiter #(
    .data_width(data_width),
    .dest_lsb  (4),
    .cnt_width (cnt_width)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .vc0_data     (vc0_data),
    .vc0_empty    (vc0_empty),
    .vc1_data     (vc1_data),
    .vc1_empty    (vc1_empty),
    .d_almost_full(d_almost_full),
    .d_full       (d_full),
    .vc0_pop      (vc0_pop),
    .vc1_pop      (vc1_pop),
    .d_push       (d_push),
    .d_data       (d_data),
    .idle         (idle),
    .active       (active),
    .vc0_xfer_cnt (vc0_xfer_cnt),
    .vc1_xfer_cnt (vc1_xfer_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [data_width-1:0] w;
    logic [cnt_width-1:0]  exp_cnt;
    n_cmp = 0;
    n_err = 0;

    reset = 1'b0; init = 1'b0;
    vc0_data = '0; vc1_data = '0;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    d_almost_full = 4'b0; d_full = 4'b0;

    // 1. reset holds everything at zero, pops forced off even with data present
    step(); step();
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    settle();
    check("rst_vc0_pop", vc0_pop, 0);
    check("rst_vc1_pop", vc1_pop, 0);
    check("rst_d_push", d_push, 0);
    check("rst_d_data", d_data, 0);
    check("rst_idle", idle, 0);
    check("rst_active", active, 0);
    check("rst_cnt0", vc0_xfer_cnt, 0);
    check("rst_cnt1", vc1_xfer_cnt, 0);
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    reset = 1'b1; init = 1'b1;
    step();
    check("init_to_idle", idle, 1);
    check("init_to_idle_active", active, 0);

    // 2. priority: VC0 wins, dest 1
    vc0_data = 6'b01_0101; vc1_data = 6'b10_0011;
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    settle();
    check("prio_vc0_pop", vc0_pop, 1);
    check("prio_vc1_pop", vc1_pop, 0);
    step();
    check("prio_d_push", d_push, 4'b0010);
    check("prio_d_data", d_data, 6'h15);
    check("prio_cnt0", vc0_xfer_cnt, 1);
    check("prio_active", active, 1);
    vc0_empty = 1'b1;
    settle();
    check("vc1_turn_pop", vc1_pop, 1);
    step();
    check("vc1_d_push", d_push, 4'b0100);
    check("vc1_d_data", d_data, 6'h23);
    check("vc1_cnt1", vc1_xfer_cnt, 1);
    vc1_empty = 1'b1;
    step();
    check("drain_d_push", d_push, 0);
    check("drain_d_data_hold", d_data, 6'h23);
    check("drain_idle", idle, 1);

    // 3. work-conserving: VC0 dest 2 almost-full, VC1 dest 3 free
    vc0_data = 6'b10_0000; vc1_data = 6'b11_0001;
    d_almost_full = 4'b0100;
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    settle();
    check("wc_vc0_pop", vc0_pop, 0);
    check("wc_vc1_pop", vc1_pop, 1);
    step();
    check("wc_d_push", d_push, 4'b1000);
    check("wc_d_data", d_data, 6'h31);
    check("wc_cnt1", vc1_xfer_cnt, 2);
    check("wc_cnt0", vc0_xfer_cnt, 1);

    // 4. both heads target dest 0 which is full
    d_almost_full = 4'b0;
    d_full = 4'b0001;
    vc0_data = 6'h05; vc1_data = 6'h0a;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("blk_vc0_pop", vc0_pop, 0);
      check("blk_vc1_pop", vc1_pop, 0);
      step();
      check("blk_d_push", d_push, 0);
      check("blk_active", active, 1);
    end
    d_full = 4'b0;
    settle();
    check("unblk_vc0_pop", vc0_pop, 1);
    check("unblk_vc1_pop", vc1_pop, 0);
    step();
    check("unblk_d_push", d_push, 4'b0001);
    check("unblk_d_data", d_data, 6'h05);
    check("unblk_cnt0", vc0_xfer_cnt, 2);
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    step();
    check("blk_drain_idle", idle, 1);

    // 5. 256 back-to-back VC0 words, dest cycling 0..3; counter passes through 0
    exp_cnt = 8'd2;
    vc0_empty = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = {i[1:0], i[5:2]};
      vc0_data = w;
      settle();
      check("strm_vc0_pop", vc0_pop, 1);
      step();
      exp_cnt = exp_cnt + 8'd1;
      check("strm_d_push", d_push, 32'(4'b0001 << i[1:0]));
      check("strm_d_data", d_data, w);
      check("strm_cnt0", vc0_xfer_cnt, exp_cnt);
      if (i == 253) check("strm_wrap_zero", vc0_xfer_cnt, 0);
    end
    check("strm_cnt0_final", vc0_xfer_cnt, 2);
    vc0_empty = 1'b1;
    step();
    check("strm_idle", idle, 1);

    // 6. init dropped in the cycle of a pop
    vc0_empty = 1'b0;
    vc0_data = 6'h19;
    step();
    check("pre_drop_d_push", d_push, 4'b0010);
    vc0_data = 6'h2a;
    init = 1'b0;
    settle();
    check("drop_vc0_pop", vc0_pop, 0);
    check("drop_inflight_push", d_push, 4'b0010);
    step();
    check("drop_d_push", d_push, 0);
    check("drop_d_data", d_data, 0);
    check("drop_cnt0", vc0_xfer_cnt, 0);
    check("drop_cnt1", vc1_xfer_cnt, 0);
    check("drop_idle", idle, 0);
    check("drop_active", active, 0);
    init = 1'b1;
    settle();
    check("reinit_no_pop", vc0_pop, 0);
    step();
    check("reinit_active", active, 1);
    check("resume_vc0_pop", vc0_pop, 1);
    step();
    check("resume_d_push", d_push, 4'b0100);
    check("resume_d_data", d_data, 6'h2a);
    check("resume_cnt0", vc0_xfer_cnt, 1);

    // 7. reset mid-operation clears immediately
    #2;
    reset = 1'b0;
    #1;
    check("midrst_d_push", d_push, 0);
    check("midrst_d_data", d_data, 0);
    check("midrst_cnt0", vc0_xfer_cnt, 0);
    check("midrst_vc0_pop", vc0_pop, 0);
    check("midrst_active", active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vc_read_arbiter.md
Name: vc_read_arbiter

Overview:
- Read side of the transaction-layer VC0/VC1 FIFOs.
- Peeks the head word of each virtual-channel FIFO and pops it when the addressed destination FIFO has room.
- Routes each popped word to one of four destination FIFOs, selected by the word's class field.
- Strict VC0-over-VC1 priority, work-conserving; keeps per-VC transfer counters for checking and debug.

Parameters:
data_width, 6, width of one FIFO word
dest_lsb, 4, LSB of the 2-bit destination field; dest = word[dest_lsb+1:dest_lsb]
cnt_width, 8, width of each per-VC transfer counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  synchronous soft init; 0 forces the INIT state
vc0_data  in  data_width  VC0 head word; valid while vc0_empty=0; advances on the clk edge that consumes vc0_pop
vc0_empty  in  1  VC0 FIFO empty
vc1_data  in  data_width  VC1 head word, same rules as vc0_data
vc1_empty  in  1  VC1 FIFO empty
d_almost_full  in  4  per-destination almost-full
d_full  in  4  per-destination full
vc0_pop  out  1  pop VC0 this cycle (combinational)
vc1_pop  out  1  pop VC1 this cycle (combinational)
d_push  out  4  one-hot push to the destination FIFO (registered)
d_data  out  data_width  word pushed (registered)
idle  out  1  state==IDLE (registered state decode)
active  out  1  state==ACTIVE
vc0_xfer_cnt  out  cnt_width  words moved from VC0
vc1_xfer_cnt  out  cnt_width  words moved from VC1

Behaviour:
- reset=0 (async, immediate):
  - state=INIT; d_push=0, d_data=0, idle=0, active=0, both counters=0.
  - Pops forced 0 combinationally.
- States: INIT, IDLE, ACTIVE. Transitions at each clk edge:
  - INIT -> IDLE when init=1 and both VCs empty.
  - INIT -> ACTIVE when init=1 and either VC is non-empty.
  - IDLE -> ACTIVE when either VC is non-empty.
  - ACTIVE -> IDLE when both VCs are empty and no pop is issued this cycle.
  - Any state -> INIT when init=0.
  - INIT behaves as reset for outputs and counters.
- Blocking: dest k is blocked when d_almost_full[k] | d_full[k]. blk0 = VC0 head dest blocked; blk1 = VC1 head dest blocked.
- Pop rules (combinational; only when state is IDLE or ACTIVE and init=1):
  - vc0_pop = ~vc0_empty & ~blk0.
  - vc1_pop = ~vc1_empty & ~blk1 & ~vc0_pop.
  - At most one pop per cycle.
  - VC1 is served when VC0 is empty or blocked (no cross-VC head-of-line blocking).
- Push latency: 1 cycle.
  - On the edge where vcX_pop=1: d_data <= vcX_data, d_push <= one-hot(dest of vcX_data).
  - Otherwise d_push <= 0 and d_data holds its value.
- Back-to-back pops on consecutive cycles are legal.
- Counters:
  - vcX_xfer_cnt increments on each edge with vcX_pop=1.
  - Wraps from 2^cnt_width-1 to 0.
- Both VCs blocked with data: state stays ACTIVE, no pops, d_push=0 from the next edge.
- Almost-full is sampled as presented, with no internal lookahead. The downstream almost-full threshold must leave at least 1 free entry to absorb the pushed word.
- init dropped mid-stream:
  - Pops go 0 in the same cycle.
  - At the next edge: d_push=0, d_data=0, counters=0, state=INIT.
  - A word already registered before the drop is pushed normally on that cycle.
- Reset asserted mid-operation: immediate clear, no partial push.
- Unused data bits pass through unmodified; the destination field is not stripped.

Test Plan:
1. Reset/init: reset=0 -> all outputs 0. Release reset with init=1 and both VCs empty -> idle=1 after 1 edge.
2. Priority routing:
   - Stimulus: vc0_data=6'b01_0101, vc1_data=6'b10_0011, both non-empty, nothing blocked.
   - Same cycle: vc0_pop=1, vc1_pop=0.
   - Next edge: d_push=4'b0010, d_data=6'h15, vc0_xfer_cnt=1.
3. Work-conserving:
   - Stimulus: VC0 head dest 2 with d_almost_full[2]=1; VC1 head 6'b11_0001 with dest 3 free.
   - Same cycle: vc1_pop=1.
   - Next edge: d_push=4'b1000, d_data=6'h31.
4. Both blocked: both heads target dest 0, d_full[0]=1 -> pops=0, active=1, d_push=0 for the duration. Release d_full[0] -> vc0_pop=1 that cycle.
5. Throughput/wrap: VC0 holds 256 words with dest cycling 0..3 -> one push per cycle with the correct one-hot, and vc0_xfer_cnt wraps to 0 after 256.
6. init drop mid-stream at the cycle of a pop:
   - That pop is suppressed (pop=0).
   - Next edge: d_push=0, counters=0, idle=0, active=0.
   - Restore init=1 -> traffic resumes from the same FIFO head.
